// File: rtl/mem_responder.sv
// Single-outstanding memory responder: word RAM behind a req/ready handshake
// with a fixed number of wait states and alignment/range fault detection.
`timescale 1ns/1ps

module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   eff_addr;
    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          fault;

    // In IDLE the live address is decoded so a zero-latency access can
    // respond on its acceptance edge; afterwards only the captured copy counts.
    always_comb begin
        eff_addr = (state == IDLE) ? addr : addr_q;
        offset   = eff_addr - BASE_ADDR;
        index    = offset[AW+1:2];
        fault    = (eff_addr[1:0] != 2'b00)
                || (eff_addr < BASE_ADDR)
                || ((offset >> (AW + 2)) != 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= 4'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 32'h0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    if (req) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        wstrb_q <= wstrb;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (LATENCY == 0) begin
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= fault;
                            if (!we)
                                rdata <= fault ? 32'h0 : mem[index];
                        end else begin
                            count <= LAT4;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= fault;
                        if (!we_q)
                            rdata <= fault ? 32'h0 : mem[index];
                    end
                end
                RESP: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writes commit on the edge leaving RESP; err already holds this access's fault.
    always_ff @(posedge clk) begin
        if (state == RESP && we_q && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b])
                    mem[index][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule
